trace_fetcher: RTL and testbench

- Upstream stage of the cache-hierarchy simulator: streams a memory-address trace out of the 32-bit trace SRAM, one word per address, in order.
- Presents each address to the simulator through a valid/ready handshake.
- Hides the SRAM's one-cycle read latency behind a 2-entry output buffer, so back-to-back delivery runs at 1 address/cycle when the consumer is always ready.
- Provides start/done control and a delivered-address count, both exposed to the logic analyzer.

---
 rtl/trace_fetcher.sv | 124 ++++++++++++
 tb/tb_trace_fetcher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_fetcher.sv
// Streams a word-addressed trace out of the trace SRAM and hands each word to the
// simulator over valid/ready, hiding the one-cycle SRAM latency with a 2-entry buffer.
//
// state  | meaning
// IDLE   | waiting for start; done holds the result of the last run
// FETCH  | issuing SRAM reads while buffer + in-flight space allows
// DRAIN  | all reads issued; waiting for the buffer to empty
// FINISH | one cycle; raises done and returns to IDLE
module trace_fetcher #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   trace_len,
   output logic              sram_csb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              addr_valid,
   output logic [DATA_W-1:0] addr_data,
   input  logic              addr_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   delivered
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   issued;
   logic              cap_q;
   logic [DATA_W-1:0] buf_mem [2];
   logic              wr_sel;
   logic              rd_sel;
   logic [1:0]        occ;
   logic              hs;
   logic              issue;

   assign addr_valid = (occ != 2'd0);
   assign addr_data  = buf_mem[rd_sel];
   assign hs         = addr_valid & addr_ready & ~abort;

   // Chip select is decoded from registered state in the same cycle: a registered
   // csb would add a cycle of latency that a 2-entry buffer cannot cover.
   // A read is allowed when the slot it will land in is guaranteed free on capture.
   assign issue = (state == FETCH) && !abort && (issued != len_q) &&
                  ((occ == 2'd0) || ((occ == 2'd1) && (!cap_q || hs)));

   assign sram_csb  = ~issue;
   assign sram_web  = 1'b1;
   assign sram_addr = rd_ptr;
   assign busy      = (state == FETCH) || (state == DRAIN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         len_q      <= '0;
         issued     <= '0;
         cap_q      <= 1'b0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_sel     <= 1'b0;
         rd_sel     <= 1'b0;
         occ        <= 2'd0;
         done       <= 1'b0;
         delivered  <= '0;
      end else if (abort) begin
         state  <= IDLE;
         cap_q  <= 1'b0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         occ    <= 2'd0;
      end else begin
         cap_q <= issue;
         if (cap_q) begin
            buf_mem[wr_sel] <= sram_dout;
            wr_sel          <= ~wr_sel;
         end
         if (hs) begin
            rd_sel    <= ~rd_sel;
            delivered <= delivered + 1'b1;
         end
         occ <= occ + {1'b0, cap_q} - {1'b0, hs};
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            issued <= issued + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  rd_ptr    <= base_addr;
                  len_q     <= trace_len;
                  issued    <= '0;
                  delivered <= '0;
                  done      <= 1'b0;
                  state     <= (trace_len == '0) ? FINISH : FETCH;
               end
            end
            FETCH: begin
               if (issue && (issued + 1'b1 == len_q))
                  state <= DRAIN;
            end
            DRAIN: begin
               if ((occ == 2'd0) && !cap_q)
                  state <= FINISH;
            end
            FINISH: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_fetcher.sv
// Directed bench for trace_fetcher: SRAM model preloaded with 0x1000+4*i, a negedge
// monitor logging reads and handshakes, and linear steps checked with assertions.
module tb_trace_fetcher;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              addr_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   trace_len = '0;
   logic              sram_csb;
   logic              sram_web;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dout = '0;
   logic              addr_valid;
   logic [DATA_W-1:0] addr_data;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   delivered;

   trace_fetcher #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .base_addr(base_addr), .trace_len(trace_len),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
      .sram_dout(sram_dout), .addr_valid(addr_valid), .addr_data(addr_data),
      .addr_ready(addr_ready), .busy(busy), .done(done), .delivered(delivered)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [1024];
   always @(posedge clk) if (!sram_csb) sram_dout <= mem[sram_addr];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int hs_cnt = 0;
   logic mon_clr = 1'b0;
   logic overread = 1'b0;
   logic busy_seen = 1'b0;
   logic [DATA_W-1:0] got [$];
   int                hs_cyc [$];
   logic [ADDR_W-1:0] rdlog [$];

   always @(negedge clk) begin
      cyc++;
      if (mon_clr) begin
         got.delete(); hs_cyc.delete(); rdlog.delete();
         rd_cnt = 0; hs_cnt = 0; overread = 1'b0; busy_seen = 1'b0;
      end else if (reset_n) begin
         if (!sram_csb) begin
            rdlog.push_back(sram_addr);
            if (rd_cnt - hs_cnt - ((addr_valid && addr_ready) ? 1 : 0) >= 2) overread = 1'b1;
            rd_cnt++;
         end
         if (addr_valid && addr_ready) begin
            got.push_back(addr_data);
            hs_cyc.push_back(cyc);
            hs_cnt++;
         end
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
   endtask

   task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
      base_addr = b;
      trace_len = l;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) step();
   endtask

   task automatic check_reset(input string pfx);
      chk({pfx, "_csb"}, sram_csb, 1);
      chk({pfx, "_sram_addr"}, sram_addr, 0);
      chk({pfx, "_valid"}, addr_valid, 0);
      chk({pfx, "_data"}, addr_data, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_delivered"}, delivered, 0);
   endtask

   task automatic run_basic(input string pfx);
      clear_mon();
      addr_ready = 1'b1;
      kick(10'd0, 11'd8);
      chk({pfx, "_p1_valid"}, addr_valid, 0);
      chk({pfx, "_p1_busy"}, busy, 1);
      chk({pfx, "_p1_done"}, done, 0);
      step();
      chk({pfx, "_p2_valid"}, addr_valid, 0);
      step();
      chk({pfx, "_p3_valid"}, addr_valid, 1);
      chk({pfx, "_p3_data"}, addr_data, 32'h1000);
      wait_done(50);
      chk({pfx, "_done"}, done, 1);
      chk({pfx, "_busy_end"}, busy, 0);
      chk({pfx, "_delivered"}, delivered, 8);
      chk({pfx, "_count"}, got.size(), 8);
      for (int i = 0; i < got.size(); i++)
         chk({pfx, "_data"}, got[i], 32'h1000 + 4 * i);
      if (hs_cyc.size() == 8)
         chk({pfx, "_back_to_back"}, hs_cyc[7] - hs_cyc[0], 7);
   endtask

   initial begin
      logic              pv;
      logic              pr;
      logic [DATA_W-1:0] pd;
      logic [ADDR_W-1:0] ea;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 4 * i;

      repeat (2) step();
      check_reset("rst");
      reset_n = 1'b1;
      step();

      run_basic("basic");

      // consumer ready pattern 1,0,0,1
      clear_mon();
      addr_ready = 1'b1;
      kick(10'd0, 11'd8);
      for (int k = 0; k < 300 && !done; k++) begin
         addr_ready = ((k % 4) == 0) || ((k % 4) == 3);
         pv = addr_valid;
         pd = addr_data;
         pr = addr_ready;
         step();
         if (pv && !pr) begin
            chk("stall_valid", addr_valid, 1);
            chk("stall_data", addr_data, pd);
         end
      end
      addr_ready = 1'b1;
      chk("toggle_done", done, 1);
      chk("toggle_count", got.size(), 8);
      for (int i = 0; i < got.size(); i++) chk("toggle_data", got[i], 32'h1000 + 4 * i);
      chk("toggle_overread", overread, 0);
      chk("toggle_reads", rdlog.size(), 8);

      // wrap from the top of the SRAM
      clear_mon();
      kick(10'd1022, 11'd4);
      wait_done(50);
      chk("wrap_done", done, 1);
      chk("wrap_delivered", delivered, 4);
      chk("wrap_reads", rdlog.size(), 4);
      for (int i = 0; i < rdlog.size(); i++) begin
         ea = 10'(1022 + i);
         chk("wrap_read_addr", rdlog[i], ea);
      end
      chk("wrap_count", got.size(), 4);
      for (int i = 0; i < got.size(); i++) begin
         ea = 10'(1022 + i);
         chk("wrap_data", got[i], 32'h1000 + 4 * ea);
      end

      // zero-length run
      clear_mon();
      kick(10'd5, 11'd0);
      chk("zero_p1_busy", busy, 0);
      chk("zero_p1_done", done, 0);
      step();
      chk("zero_p2_done", done, 1);
      step();
      chk("zero_reads", rdlog.size(), 0);
      chk("zero_busy_seen", busy_seen, 0);
      chk("zero_delivered", delivered, 0);

      // abort after 10 handshakes with a read in flight
      clear_mon();
      addr_ready = 1'b1;
      kick(10'd0, 11'd100);
      for (int i = 0; i < 200 && delivered < 10; i++) step();
      addr_ready = 1'b0;
      abort = 1'b1;
      chk("abort_pre_delivered", delivered, 10);
      step();
      abort = 1'b0;
      chk("abort_valid", addr_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_delivered", delivered, 10);
      chk("abort_count", got.size(), 10);
      step();
      chk("abort_inflight_dropped", addr_valid, 0);
      chk("abort_delivered_hold", delivered, 10);
      clear_mon();
      addr_ready = 1'b1;
      kick(10'd0, 11'd3);
      wait_done(50);
      chk("rerun_done", done, 1);
      chk("rerun_delivered", delivered, 3);
      chk("rerun_count", got.size(), 3);
      for (int i = 0; i < got.size(); i++) chk("rerun_data", got[i], 32'h1000 + 4 * i);

      // asynchronous reset mid-run
      clear_mon();
      kick(10'd0, 11'd8);
      repeat (3) step();
      chk("mid_valid_before", addr_valid, 1);
      reset_n = 1'b0;
      #2;
      check_reset("midrst");
      step();
      chk("midrst_hold_busy", busy, 0);
      chk("midrst_hold_valid", addr_valid, 0);
      reset_n = 1'b1;
      repeat (3) step();
      chk("post_idle_busy", busy, 0);
      chk("post_idle_csb", sram_csb, 1);
      chk("post_idle_valid", addr_valid, 0);
      run_basic("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
